// File: rtl/psk_prbs_ber_monitor.sv
// ----------------------------------------------------------------------------
// psk_prbs_ber_monitor
// Self-synchronising PRBS bit-error monitor for the PSK Rx demodulator output.
// Loads received bits into a local LFSR until it holds a full PRBS state. It
// then free-runs from its own prediction and counts compared bits, bit errors
// and lock losses. A sliding-free fixed window drops lock when the error
// density is too high.
// ----------------------------------------------------------------------------
module psk_prbs_ber_monitor #(
   parameter  int PRBS_ORDER = 7,
   parameter  int BPS_MAX    = 2,
   parameter  int CNT_W      = 32,
   parameter  int WIN_BITS   = 64,
   parameter  int ERR_THR    = 8,
   localparam int BPS_W      = $clog2(BPS_MAX + 1)
) (
   input  logic               clk_16M384,
   input  logic               rst_n_16M384,
   input  logic [BPS_MAX-1:0] sym_bits,
   input  logic               sym_vld,
   input  logic [BPS_W-1:0]   bps,
   input  logic               clear,
   output logic               locked,
   output logic [CNT_W-1:0]   bit_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [15:0]        lock_loss_cnt
);

   // Second feedback tap of the supported polynomials x^N + x^TAP + 1.
   localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                        (PRBS_ORDER == 9)  ? 5  :
                        (PRBS_ORDER == 15) ? 14 :
                        (PRBS_ORDER == 23) ? 18 : 28;

   // Fill can overshoot the order by up to one symbol before lock is taken.
   localparam int FILL_W = $clog2(PRBS_ORDER + BPS_MAX + 1);
   // Window counters can overshoot WIN_BITS by up to one symbol.
   localparam int WIN_W  = $clog2(WIN_BITS + BPS_MAX + 1);
   localparam int CNT_W1 = CNT_W + 1;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Registered state
   state_t                state_q,         state_d;
   logic [PRBS_ORDER-1:0] lfsr_q,          lfsr_d;
   logic [FILL_W-1:0]     fill_q,          fill_d;
   logic [WIN_W-1:0]      win_bits_q,      win_bits_d;
   logic [WIN_W-1:0]      win_err_q,       win_err_d;
   logic [BPS_W-1:0]      prev_bps_q,      prev_bps_d;
   logic [CNT_W-1:0]      bit_cnt_q,       bit_cnt_d;
   logic [CNT_W-1:0]      err_cnt_q,       err_cnt_d;
   logic [15:0]           lock_loss_cnt_q, lock_loss_cnt_d;

   // Per-symbol combinational results
   logic                  sym_ok;
   logic                  bps_chg;
   state_t                sym_state;
   logic [BPS_MAX-1:0]    aligned;
   logic                  pred;
   logic                  rx;
   logic [PRBS_ORDER-1:0] lfsr_nxt;
   logic [BPS_W-1:0]      sym_err;
   logic [FILL_W-1:0]     fill_base;
   logic [FILL_W-1:0]     fill_sum;
   logic [WIN_W-1:0]      win_bits_sum;
   logic [WIN_W-1:0]      win_err_sum;
   logic [BPS_W-1:0]      cnt_bits;
   logic [BPS_W-1:0]      cnt_errs;
   logic                  lose;
   logic [CNT_W:0]        bit_sum;
   logic [CNT_W:0]        err_sum;

   // Qualify the strobe and decide which state this symbol is processed in.
   always_comb begin
      sym_ok    = sym_vld && (bps != '0) && (bps <= BPS_W'(BPS_MAX));
      bps_chg   = sym_ok && (bps != prev_bps_q);
      // A modulation change invalidates the current alignment: treat the
      // symbol as the first one of a fresh search.
      sym_state = bps_chg ? ST_SEARCH : state_q;
   end

   // Walk the symbol's bits oldest first through the LFSR in one cycle.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      lfsr_nxt = lfsr_q;
      sym_err  = '0;
      pred     = 1'b0;
      rx       = 1'b0;
      // Left-justify the active bits so the oldest one always sits at the MSB.
      aligned  = sym_bits << (BPS_W'(BPS_MAX) - bps);
      for (int j = 0; j < BPS_MAX; j++) begin
         if (j < int'(bps)) begin
            pred = lfsr_nxt[PRBS_ORDER-1] ^ lfsr_nxt[TAP-1];
            rx   = aligned[BPS_MAX-1-j];
            if (sym_state == ST_LOCKED) begin
               // Free-run on the prediction so line errors never reach the reference.
               lfsr_nxt = {lfsr_nxt[PRBS_ORDER-2:0], pred};
               if (rx != pred) begin
                  sym_err = sym_err + BPS_W'(1);
               end
            end else begin
               lfsr_nxt = {lfsr_nxt[PRBS_ORDER-2:0], rx};
            end
         end
      end
   end

   // Lock state machine: fill tracking in SEARCH, window evaluation in LOCKED.
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      fill_d       = fill_q;
      win_bits_d   = win_bits_q;
      win_err_d    = win_err_q;
      prev_bps_d   = prev_bps_q;
      cnt_bits     = '0;
      cnt_errs     = '0;
      lose         = 1'b0;
      fill_base    = fill_q;
      fill_sum     = '0;
      win_bits_sum = '0;
      win_err_sum  = '0;

      if (sym_ok) begin
         prev_bps_d = bps;
         lfsr_d     = lfsr_nxt;
         lose       = bps_chg && (state_q == ST_LOCKED);

         if (sym_state == ST_SEARCH) begin
            if (bps_chg) begin
               fill_base = '0;
            end
            fill_sum   = fill_base + FILL_W'(bps);
            fill_d     = fill_sum;
            win_bits_d = '0;
            win_err_d  = '0;
            state_d    = (fill_sum >= FILL_W'(PRBS_ORDER)) ? ST_LOCKED : ST_SEARCH;
         end else begin
            cnt_bits     = bps;
            cnt_errs     = sym_err;
            win_bits_sum = win_bits_q + WIN_W'(bps);
            win_err_sum  = win_err_q + WIN_W'(sym_err);
            if (win_bits_sum >= WIN_W'(WIN_BITS)) begin
               // Window closes; any overshoot bits are deliberately discarded.
               win_bits_d = '0;
               win_err_d  = '0;
               if (win_err_sum > WIN_W'(ERR_THR)) begin
                  state_d = ST_SEARCH;
                  fill_d  = '0;
                  lose    = 1'b1;
               end
            end else begin
               win_bits_d = win_bits_sum;
               win_err_d  = win_err_sum;
            end
         end
      end
   end

   // Saturating statistics counters; clear overrides the current symbol's counts.
   always_comb begin
      bit_sum         = {1'b0, bit_cnt_q} + CNT_W1'(cnt_bits);
      err_sum         = {1'b0, err_cnt_q} + CNT_W1'(cnt_errs);
      bit_cnt_d       = bit_cnt_q;
      err_cnt_d       = err_cnt_q;
      lock_loss_cnt_d = lock_loss_cnt_q;
      if (clear) begin
         bit_cnt_d       = '0;
         err_cnt_d       = '0;
         lock_loss_cnt_d = '0;
      end else begin
         bit_cnt_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
         err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
         if (lose && (lock_loss_cnt_q != '1)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
         end
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk_16M384) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (!rst_n_16M384) begin
         state_q         <= ST_SEARCH;
         lfsr_q          <= '0;
         fill_q          <= '0;
         win_bits_q      <= '0;
         win_err_q       <= '0;
         prev_bps_q      <= '0;
         bit_cnt_q       <= '0;
         err_cnt_q       <= '0;
         lock_loss_cnt_q <= '0;
      end else begin
         state_q         <= state_d;
         lfsr_q          <= lfsr_d;
         fill_q          <= fill_d;
         win_bits_q      <= win_bits_d;
         win_err_q       <= win_err_d;
         prev_bps_q      <= prev_bps_d;
         bit_cnt_q       <= bit_cnt_d;
         err_cnt_q       <= err_cnt_d;
         lock_loss_cnt_q <= lock_loss_cnt_d;
      end
   end

   assign locked        = (state_q == ST_LOCKED);
   assign bit_cnt       = bit_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_psk_prbs_ber_monitor.sv
// ----------------------------------------------------------------------------
// tb_psk_prbs_ber_monitor
// Directed scenarios plus a randomized phase against a sequence-level model of
// the PRBS checker. A second instance with 4-bit counters covers saturation.
// ----------------------------------------------------------------------------
module tb_psk_prbs_ber_monitor;

   localparam int ORDER    = 7;
   localparam int TAP_B    = 6;   // x^7 + x^6 + 1
   localparam int BPS_MAX  = 2;
   localparam int WIN_BITS = 64;
   localparam int ERR_THR  = 8;

   logic        clk_16M384   = 1'b0;
   logic        rst_n_16M384 = 1'b0;
   logic [1:0]  sym_bits     = '0;
   logic        sym_vld      = 1'b0;
   logic [1:0]  bps          = 2'd1;
   logic        clear        = 1'b0;

   logic        locked,   locked_s;
   logic [31:0] bit_cnt,  err_cnt;
   logic [3:0]  bit_cnt_s, err_cnt_s;
   logic [15:0] loss,     loss_s;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk_16M384 = ~clk_16M384;

   psk_prbs_ber_monitor dut (
      .clk_16M384   (clk_16M384),
      .rst_n_16M384 (rst_n_16M384),
      .sym_bits     (sym_bits),
      .sym_vld      (sym_vld),
      .bps          (bps),
      .clear        (clear),
      .locked       (locked),
      .bit_cnt      (bit_cnt),
      .err_cnt      (err_cnt),
      .lock_loss_cnt(loss)
   );

   psk_prbs_ber_monitor #(.CNT_W(4)) dut_sat (
      .clk_16M384   (clk_16M384),
      .rst_n_16M384 (rst_n_16M384),
      .sym_bits     (sym_bits),
      .sym_vld      (sym_vld),
      .bps          (bps),
      .clear        (clear),
      .locked       (locked_s),
      .bit_cnt      (bit_cnt_s),
      .err_cnt      (err_cnt_s),
      .lock_loss_cnt(loss_s)
   );

   // ---------------- reference model (bit-sequence level) ----------------
   bit     m_ref[$];      // reference bit sequence, newest at the back
   bit     m_locked;
   int     m_fill, m_wb, m_we, m_prev_bps;
   longint m_bits, m_errs, m_loss;   // unbounded; saturation applied on compare

   bit     tx_hist[$];    // transmitted PRBS sequence

   function automatic void tx_seed();
      tx_hist.delete();
      for (int i = 0; i < ORDER; i++) tx_hist.push_back(1'($urandom));
      tx_hist[0] = 1'b1;   // never the all-zero lockup state
   endfunction

   function automatic bit tx_next();
      bit b;
      b = tx_hist[tx_hist.size()-ORDER] ^ tx_hist[tx_hist.size()-TAP_B];
      tx_hist.push_back(b);
      if (tx_hist.size() > 64) void'(tx_hist.pop_front());
      return b;
   endfunction

   function automatic void model_reset();
      m_ref.delete();
      for (int i = 0; i < ORDER; i++) m_ref.push_back(1'b0);
      m_locked = 1'b0; m_fill = 0; m_wb = 0; m_we = 0; m_prev_bps = 0;
      m_bits = 0; m_errs = 0; m_loss = 0;
   endfunction

   function automatic void model_step(input logic [1:0] bits, input int b, input bit vld, input bit clr);
      int nb;  int ne;  bit lose;  bit search;  bit pred;  bit rxb;
      nb = 0; ne = 0; lose = 1'b0;
      if (vld && b >= 1 && b <= BPS_MAX) begin
         if (b != m_prev_bps) begin
            if (m_locked) lose = 1'b1;
            m_locked = 1'b0; m_fill = 0; m_wb = 0; m_we = 0;
         end
         m_prev_bps = b;
         search = !m_locked;
         for (int k = b - 1; k >= 0; k--) begin
            rxb = bits[k];
            if (search) begin
               m_ref.push_back(rxb);
               m_fill++;
            end else begin
               pred = m_ref[m_ref.size()-ORDER] ^ m_ref[m_ref.size()-TAP_B];
               m_ref.push_back(pred);
               nb++;
               if (rxb != pred) ne++;
            end
            if (m_ref.size() > 64) void'(m_ref.pop_front());
         end
         if (search) begin
            if (m_fill >= ORDER) m_locked = 1'b1;
         end else begin
            m_wb += b;
            m_we += ne;
            if (m_wb >= WIN_BITS) begin
               if (m_we > ERR_THR) begin
                  m_locked = 1'b0; m_fill = 0; lose = 1'b1;
               end
               m_wb = 0; m_we = 0;
            end
         end
      end
      if (clr) begin
         m_bits = 0; m_errs = 0; m_loss = 0;
      end else begin
         m_bits += nb;
         m_errs += ne;
         if (lose) m_loss++;
      end
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("locked",          locked,    64'(m_locked));
      check("bit_cnt",         bit_cnt,   sat(m_bits, 32));
      check("err_cnt",         err_cnt,   sat(m_errs, 32));
      check("lock_loss_cnt",   loss,      sat(m_loss, 16));
      check("sat.locked",      locked_s,  64'(m_locked));
      check("sat.bit_cnt",     bit_cnt_s, sat(m_bits, 4));
      check("sat.err_cnt",     err_cnt_s, sat(m_errs, 4));
      check("sat.lock_loss",   loss_s,    sat(m_loss, 16));
   endtask

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic apply(input logic [1:0] bits, input logic [1:0] b, input bit vld, input bit clr);
      sym_bits = bits; bps = b; sym_vld = vld; clear = clr;
      @(negedge clk_16M384);
      model_step(bits, int'(b), vld, clr);
      sym_vld = 1'b0; clear = 1'b0;
      check_all();
   endtask

   task automatic send(input int b, input logic [1:0] emask, input bit clr, input int gap);
      logic [1:0] bits;
      bits = 2'($urandom);   // unused upper bit carries junk in BPSK
      for (int k = b - 1; k >= 0; k--) bits[k] = tx_next();
      apply(bits ^ emask, 2'(b), 1'b1, clr);
      repeat (gap) @(negedge clk_16M384);
   endtask

   task automatic do_reset();
      rst_n_16M384 = 1'b0; sym_vld = 1'b1; sym_bits = 2'($urandom); bps = 2'd1; clear = 1'b0;
      @(negedge clk_16M384);
      model_reset();
      rst_n_16M384 = 1'b1; sym_vld = 1'b0;
      check("rst_locked",  locked,  0);
      check("rst_bit_cnt", bit_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_loss",    loss,    0);
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur_b;
      int r;
      int guard;
      logic [1:0] em;

      tx_seed();
      do_reset();

      // 1: BPSK, one symbol per 16 clocks, error free
      for (int i = 1; i <= 1000; i++) begin
         send(1, 2'b00, 1'b0, 15);
         if (i == 6) check("t1_unlocked_after_6", locked, 0);
         if (i == 7) check("t1_locked_after_7",   locked, 1);
      end
      check("t1_bit_cnt",     bit_cnt,   993);
      check("t1_err_cnt",     err_cnt,   0);
      check("t6_sat_bit_cnt", bit_cnt_s, 15);

      // 2: QPSK, error free, random gaps including back-to-back
      tx_seed();
      do_reset();
      for (int i = 1; i <= 104; i++) begin
         send(2, 2'b00, 1'b0, $urandom_range(0, 2));
         if (i == 3) check("t2_unlocked_after_3", locked, 0);
         if (i == 4) check("t2_locked_after_4",   locked, 1);
      end
      check("t2_bit_cnt", bit_cnt, 200);
      check("t2_err_cnt", err_cnt, 0);

      // 3: single error while locked, then exactly ERR_THR errors in a window
      do_reset();
      for (int i = 0; i < 10; i++) send(1, 2'b00, 1'b0, 0);
      send(1, 2'b01, 1'b0, 1);
      check("t3_err_cnt_1",   err_cnt, 1);
      check("t3_locked",      locked,  1);
      check("t3_loss_0",      loss,    0);
      guard = 0;
      do begin send(1, 2'b00, 1'b0, 0); guard++; end while (m_wb != 0 && guard < 80);
      for (int i = 0; i < ERR_THR; i++) send(1, 2'b01, 1'b0, 0);
      guard = 0;
      do begin send(1, 2'b00, 1'b0, 0); guard++; end while (m_wb != 0 && guard < 80);
      check("t3_thr_locked",  locked,  1);
      check("t3_thr_loss_0",  loss,    0);
      check("t3_thr_err_cnt", err_cnt, 9);

      // 4: nine errors in one window drop lock; clean stream relocks
      for (int i = 0; i < ERR_THR + 1; i++) send(1, 2'b01, 1'b0, 0);
      guard = 0;
      while (m_locked && guard < 80) begin send(1, 2'b00, 1'b0, 0); guard++; end
      check("t4_unlocked", locked, 0);
      check("t4_loss_1",   loss,   1);
      for (int i = 0; i < 6; i++) send(1, 2'b00, 1'b0, 0);
      check("t4_unlocked_after_6", locked, 0);
      send(1, 2'b00, 1'b0, 0);
      check("t4_relocked_after_7", locked, 1);

      // 5: clear with simultaneous symbol, then a bps change while locked
      for (int i = 0; i < 5; i++) send(1, 2'b01, 1'b0, 0);
      send(1, 2'b00, 1'b1, 0);
      check("t5_clr_bit_cnt", bit_cnt, 0);
      check("t5_clr_err_cnt", err_cnt, 0);
      check("t5_clr_loss",    loss,    0);
      check("t5_clr_locked",  locked,  1);
      send(2, 2'b00, 1'b0, 0);
      check("t5_bps_unlocked", locked, 0);
      check("t5_bps_loss",     loss,   1);
      for (int i = 0; i < 3; i++) send(2, 2'b00, 1'b0, 0);
      check("t5_qpsk_relocked", locked, 1);

      // Randomized phase: valid/invalid strobes, errors, bursts, clears, bps flips
      cur_b = 2;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            apply(2'($urandom), (r == 0) ? 2'd0 : 2'd3, 1'b1, ($urandom_range(0, 9) == 0));
         end else begin
            if (r < 5) cur_b = 3 - cur_b;
            em = '0;
            for (int k = 0; k < cur_b; k++) if ($urandom_range(0, 39) == 0) em[k] = 1'b1;
            if ($urandom_range(0, 49) == 0) em = '1;
            send(cur_b, em, ($urandom_range(0, 199) == 0), $urandom_range(0, 2));
         end
      end

      // 6: reset mid-stream while locked, then normal relock
      for (int i = 0; i < 12; i++) send(1, 2'b00, 1'b0, 0);
      do_reset();
      for (int i = 0; i < 6; i++) send(1, 2'b00, 1'b0, 0);
      check("t6_unlocked_after_6", locked, 0);
      send(1, 2'b00, 1'b0, 0);
      check("t6_relocked_after_7", locked, 1);
      for (int i = 0; i < 20; i++) send(1, 2'b00, 1'b0, 0);
      check("t6_bit_cnt", bit_cnt, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
